regfile_debug_master: RTL and testbench
=======================================

Name: regfile_debug_master

Overview:
- Debug-side initiator for the register_file port set: accepts single-register read/write commands and full-file dump commands on a valid/ready command channel.
- Drives the register file's write and read ports to carry out each command.
- Returns results on a valid/ready response channel.
- Sits beside the core; the top level muxes register-file ports to this block while dbg_active=1.

Parameters:
NUM_REGS, 32, number of architectural registers swept by a dump
IDX_W, 5, register index width
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, rising-edge
nRST  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command
cmd_write  input  1  1=write, 0=read
cmd_dump  input  1  1=dump all registers (ignored when cmd_write=1)
cmd_index  input  IDX_W  target register
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_index  output  IDX_W  register the response refers to
rsp_data  output  DATA_W  register value read
rsp_last  output  1  final beat of a dump; 1 on every single-register response
dbg_active  output  1  block owns register-file ports (state != IDLE)
rf_reg_write  output  1  to register_file reg_write
rf_write_index  output  IDX_W  to register_file write_index
rf_write_data  output  DATA_W  to register_file write_data
rf_read_index  output  IDX_W  to register_file read_index1
rf_read_data  input  DATA_W  from register_file read_data1 (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset nRST is asynchronous and active-low.
- While nRST=0:
  - State is IDLE.
  - All registered outputs and the latched index/data are 0.
  - cmd_ready=0.
  - rf_reg_write drops immediately (asynchronously).
- After reset release: cmd_ready = (state==IDLE).
- States: IDLE, WRITE, READ, RESP, DUMP_READ, DUMP_RESP.
- IDLE:
  - cmd_ready=1. rf_reg_write=0. rf_read_index=0.
  - A handshake is cmd_valid & cmd_ready at a rising edge. On handshake, latch index and wdata, then branch:
  - cmd_write=1 -> WRITE.
  - cmd_dump=1 (and cmd_write=0) -> DUMP_READ with index=0.
  - otherwise -> READ.
- WRITE (exactly 1 cycle):
  - rf_write_index=idx, rf_write_data=wdata.
  - rf_reg_write=1 only if idx!=0; index 0 writes are suppressed.
  - Next state is READ (read-back).
- READ (1 cycle):
  - rf_read_index=idx.
  - At the end of the cycle, capture rsp_data<=rf_read_data and rsp_index<=idx; rsp_last<=1.
  - Next state is RESP.
- RESP:
  - rsp_valid=1. rsp_index, rsp_data and rsp_last are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready -> IDLE.
- Latency, with accepting edge E0:
  - Read: rsp_valid is visible after edge E1.
  - Write: rf_reg_write is high during E0–E1; the file updates at E1; rsp_valid is visible after E2 carrying the read-back value.
- DUMP_READ: same as READ, except rsp_last<=(idx==NUM_REGS-1). Next state is DUMP_RESP.
- DUMP_RESP:
  - rsp_valid=1.
  - On handshake: if rsp_last -> IDLE; else idx<=idx+1 -> DUMP_READ.
  - With rsp_ready tied high, a dump takes 2*NUM_REGS cycles, produces indices 0..NUM_REGS-1 in order, and has no gaps other than the READ cycles.
- Index counter: IDX_W bits, never wraps; the dump terminates at NUM_REGS-1.
- Commands arriving when state!=IDLE are not accepted (cmd_ready=0). The block holds no command queue.
- cmd_write=1 with cmd_dump=1 is treated as a write.
- Register 0 always reads back 0; a write to 0 responds with rsp_data=0.
- Reset mid-operation:
  - Abandon the command and emit no partial response.
  - rsp_valid=0 and rf_reg_write=0 immediately.
  - A dump in progress is not resumed.
- rf_reg_write is never asserted outside WRITE.

Test Plan:
- Reset: hold nRST=0 for 3 cycles -> cmd_ready=0, rsp_valid=0, rf_reg_write=0, dbg_active=0; release -> cmd_ready=1 at next cycle.
- Write/read-back: write idx=1, wdata=0xAAAAAAAA, rsp_ready=1 -> rf_reg_write high exactly one cycle with index 1; response rsp_index=1, rsp_data=0xAAAAAAAA, rsp_last=1, two edges after the write pulse.
- Overwrite then read: write idx=1 0xAAAAAAAF, then read idx=1 -> read response 0xAAAAAAAF, one edge after accept; reading idx=0 after writing 0xFACEAAAA to idx 0 -> rf_reg_write never high, rsp_data=0.
- Backpressure: read idx=2 (holding 0xFACEAAAA) with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data=0xFACEAAAA, rsp_index=2 stable for all 5 cycles; cmd_ready=0 and a second command is not accepted until the handshake completes.
- Dump: preload idx 2,4,8,16 = 0xFACEAAAA, 0xAAAAFACE, 0xAAFACEAA, 0xFAAAAACE; issue dump with rsp_ready=1 -> 32 beats indices 0..31 with matching data (others 0); rsp_last only on index 31; total 64 cycles; then back in IDLE.
- Reset mid-dump: assert nRST=0 at beat 10 -> rsp_valid falls immediately; after release the next read of idx 4 returns 0 (file reset) and no stale beats appear.

Source files
------------

// File: rtl/regfile_debug_master.sv
// Debug-side initiator for the register file: single read/write commands and full-file dumps
// over a valid/ready command channel, with results returned on a valid/ready response channel.
module regfile_debug_master #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_dump,
  input  logic [IDX_W-1:0]  cmd_index,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDX_W-1:0]  rsp_index,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              dbg_active,
  output logic              rf_reg_write,
  output logic [IDX_W-1:0]  rf_write_index,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [IDX_W-1:0]  rf_read_index,
  input  logic [DATA_W-1:0] rf_read_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, DUMP_READ, DUMP_RESP} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdata;
  logic              cmd_hs;

  // cmd_ready is gated by reset so nothing is accepted while nRST is low
  assign cmd_ready    = nRST & (state == IDLE);
  assign cmd_hs       = cmd_valid & cmd_ready;
  assign dbg_active   = (state != IDLE);
  assign rsp_valid    = (state == RESP) | (state == DUMP_RESP);
  assign rf_reg_write = (state == WRITE) & (idx != '0);
  assign rf_write_index = idx;
  assign rf_write_data  = wdata;
  assign rf_read_index  = ((state == READ) | (state == DUMP_READ)) ? idx : '0;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_hs) begin
        if (cmd_write)     state_nxt = WRITE;
        else if (cmd_dump) state_nxt = DUMP_READ;
        else               state_nxt = READ;
      end
      WRITE:     state_nxt = READ;
      READ:      state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      DUMP_READ: state_nxt = DUMP_RESP;
      DUMP_RESP: if (rsp_ready) state_nxt = rsp_last ? IDLE : DUMP_READ;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      idx       <= '0;
      wdata     <= '0;
      rsp_index <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_hs) begin
          idx   <= (cmd_dump & ~cmd_write) ? '0 : cmd_index;
          wdata <= cmd_wdata;
        end
        READ, DUMP_READ: begin
          rsp_data  <= rf_read_data;
          rsp_index <= idx;
          rsp_last  <= (state == READ) | (idx == LAST_IDX);
        end
        // advance only after the consumer took the beat; last beat leaves idx in range
        DUMP_RESP: if (rsp_ready & ~rsp_last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_master.sv
// Randomized bench for regfile_debug_master: behavioural register-file environment plus a
// shadow-array reference model of what each response must carry.
module tb_regfile_debug_master;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_dump = 1'b0;
  logic [IDX_W-1:0]  cmd_index = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_last, dbg_active, rf_reg_write;
  logic [IDX_W-1:0]  rsp_index, rf_write_index, rf_read_index;
  logic [DATA_W-1:0] rsp_data, rf_write_data, rf_read_data;

  regfile_debug_master #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_dump(cmd_dump),
    .cmd_index(cmd_index), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_index(rsp_index), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .dbg_active(dbg_active),
    .rf_reg_write(rf_reg_write), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .rf_read_index(rf_read_index), .rf_read_data(rf_read_data)
  );

  always #5 clk = ~clk;

  // register file environment: reg 0 hardwired to zero, combinational read, cleared by reset
  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
    end else if (rf_reg_write) begin
      rf_mem[rf_write_index] <= rf_write_data;
    end
  end
  assign rf_read_data = (rf_read_index == '0) ? '0 : rf_mem[rf_read_index];

  // reference model: what the file should hold, updated per command
  logic [DATA_W-1:0] ref_mem [NUM_REGS];
  int exp_wr_pulses = 0;
  int wr_pulses = 0;
  always @(negedge clk) if (rf_reg_write) wr_pulses++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < NUM_REGS; i++) ref_mem[i] = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    clear_ref();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_reg_write", {31'b0, rf_reg_write}, 32'd0);
    chk("rst_dbg_active", {31'b0, dbg_active}, 32'd0);
    nRST = 1'b1;
    @(posedge clk); #1;
    chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  // single read or write (dump flag alongside write must behave as a write)
  task automatic do_single(input logic w, input logic d, input int idx, input logic [31:0] data,
                           input int stall);
    logic [31:0] exp;
    if (w && idx != 0) begin
      ref_mem[idx] = data;
      exp_wr_pulses++;
    end
    exp = ref_mem[idx];
    wait_ready();
    cmd_valid = 1'b1; cmd_write = w; cmd_dump = d;
    cmd_index = IDX_W'(idx); cmd_wdata = data; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("accept_dbg_active", {31'b0, dbg_active}, 32'd1);
    if (w) begin
      chk("wr_pulse", {31'b0, rf_reg_write}, {31'b0, idx != 0});
      chk("wr_index", {27'b0, rf_write_index}, idx);
      chk("wr_data", rf_write_data, data);
      chk("wr_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("wr_pulse_end", {31'b0, rf_reg_write}, 32'd0);
    end
    chk("rsp_not_early", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_dump = 1'b0;
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, exp);
      chk("stall_index", {27'b0, rsp_index}, idx);
      chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("rsp_valid_hold", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_index", {27'b0, rsp_index}, idx);
    chk("rsp_last", {31'b0, rsp_last}, 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  // full dump with rsp_ready held high; abort_beat >= 0 resets the block at that beat
  task automatic do_dump(input int abort_beat);
    int cyc = 0;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_dump = 1'b1;
    cmd_index = IDX_W'($urandom_range(1, NUM_REGS - 1)); rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_dump = 1'b0;
    for (int b = 0; b < NUM_REGS; b++) begin
      @(posedge clk); #1; cyc++;
      chk("dump_valid", {31'b0, rsp_valid}, 32'd1);
      chk("dump_index", {27'b0, rsp_index}, b);
      chk("dump_data", rsp_data, ref_mem[b]);
      chk("dump_last", {31'b0, rsp_last}, {31'b0, b == NUM_REGS - 1});
      if (b == abort_beat) begin
        nRST = 1'b0;
        #1;
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_reg_write", {31'b0, rf_reg_write}, 32'd0);
        chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        clear_ref();
        rsp_ready = 1'b0;
        return;
      end
      @(posedge clk); #1; cyc++;
      if (b < NUM_REGS - 1) begin
        chk("dump_gap", {31'b0, rsp_valid}, 32'd0);
        chk("dump_active", {31'b0, dbg_active}, 32'd1);
      end else begin
        chk("dump_end_idle", {31'b0, cmd_ready}, 32'd1);
        chk("dump_cycles", cyc, 2 * NUM_REGS);
      end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    clear_ref();
    apply_reset();

    do_single(1'b1, 1'b0, 1, 32'hAAAAAAAA, 0);
    do_single(1'b1, 1'b0, 1, 32'hAAAAAAAF, 0);
    do_single(1'b0, 1'b0, 1, 32'h0, 0);
    do_single(1'b1, 1'b0, 0, 32'hFACEAAAA, 0);
    do_single(1'b0, 1'b0, 0, 32'h0, 0);
    do_single(1'b1, 1'b0, 2, 32'hFACEAAAA, 0);
    do_single(1'b0, 1'b0, 2, 32'h0, 5);
    do_single(1'b1, 1'b0, 4, 32'hAAAAFACE, 0);
    do_single(1'b1, 1'b0, 8, 32'hAAFACEAA, 0);
    do_single(1'b1, 1'b0, 16, 32'hFAAAAACE, 0);
    do_dump(-1);

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 2);
      do_single(op != 1, op == 2, $urandom_range(0, NUM_REGS - 1), $urandom,
                $urandom_range(0, 3));
    end

    do_dump(10);
    repeat (3) @(posedge clk);
    #1 nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_abort_no_beat", {31'b0, rsp_valid}, 32'd0);
    end
    do_single(1'b0, 1'b0, 4, 32'h0, 0);
    do_dump(-1);

    chk("wr_pulse_count", wr_pulses, exp_wr_pulses);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
